// File: rtl/ram_bus_master.sv
// Byte-wide initiator for the single-port synchronous RAM bus.
// Sequences direct reads/writes and pointer-indirect accesses via a 13-bit pointer fetched from RAM.
module ram_bus_master #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_indirect,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [ADDR_WIDTH-1:0] ram_indirect_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam int HI_BITS = ADDR_WIDTH - DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, PLO_ISS, PLO_WT, PHI_ISS, PHI_WT, RD_ISS, RD_WT, WR
  } state_t;

  state_t                  state_reg, state_next;
  logic                    ram_cs_reg, ram_we_reg, ram_oe_reg;
  logic                    cs_next, we_next, oe_next;
  logic [ADDR_WIDTH-1:0]   ram_addr_reg, addr_next;
  logic                    write_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   ptr_lo_reg;
  logic                    rsp_valid_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic [ADDR_WIDTH-1:0]   rsp_addr_reg;
  logic                    accept;
  logic                    done;

  assign req_ready = (state_reg == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign done      = (state_reg == RD_WT) || (state_reg == WR);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Bus controls are derived from the next state so they are registered and
  // stable for the entire duration of each state.
  always_comb begin
    state_next = state_reg;
    addr_next  = ram_addr_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          addr_next = req_addr;
          if (req_indirect)   state_next = PLO_ISS;
          else if (req_write) state_next = WR;
          else                state_next = RD_ISS;
        end
      end
      PLO_ISS: state_next = PLO_WT;
      PLO_WT: begin
        state_next = PHI_ISS;
        addr_next  = ram_addr_reg + ADDR_WIDTH'(1);
      end
      PHI_ISS: state_next = PHI_WT;
      PHI_WT: begin
        // High pointer byte is still on the bus here; its top bits are dropped.
        addr_next  = {ram_data[HI_BITS-1:0], ptr_lo_reg};
        state_next = write_reg ? WR : RD_ISS;
      end
      RD_ISS:  state_next = RD_WT;
      RD_WT:   state_next = IDLE;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
    cs_next = (state_next != IDLE);
    we_next = (state_next == WR);
    oe_next = cs_next && !we_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cs_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_oe_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      write_reg     <= 1'b0;
      wdata_reg     <= '0;
      ptr_lo_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_addr_reg  <= '0;
    end else begin
      ram_cs_reg    <= cs_next;
      ram_we_reg    <= we_next;
      ram_oe_reg    <= oe_next;
      ram_addr_reg  <= addr_next;
      rsp_valid_reg <= done;
      if (accept) begin
        write_reg <= req_write;
        wdata_reg <= req_wdata;
      end
      if (state_reg == PLO_WT) ptr_lo_reg <= ram_data;
      if (state_reg == RD_WT)  rsp_rdata_reg <= ram_data;
      // The address register already holds the effective address in RD_WT/WR.
      if (done) rsp_addr_reg <= ram_addr_reg;
    end
  end

  assign ram_cs            = ram_cs_reg;
  assign ram_we            = ram_we_reg;
  assign ram_oe            = ram_oe_reg;
  assign ram_addr          = ram_addr_reg;
  assign ram_indirect_addr = '0;
  assign rsp_valid         = rsp_valid_reg;
  assign rsp_rdata         = rsp_rdata_reg;
  assign rsp_addr          = rsp_addr_reg;
  assign ram_data = (ram_cs_reg && ram_we_reg && !ram_oe_reg) ? wdata_reg : 'z;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: behavioural sync RAM, scoreboard of expected responses,
// one task per scenario.
module tb_ram_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_indirect = 1'b0;
  logic [12:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [12:0] rsp_addr;
  logic        ram_cs, ram_we, ram_oe;
  logic [12:0] ram_addr;
  logic [12:0] ram_indirect_addr;
  wire  [7:0]  ram_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cnt = 0;
  logic [7:0] model_rdata = 8'h00;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  // RAM model: samples address at the end of an issue cycle, drives data the next cycle.
  logic [7:0]  mem [0:8191];
  logic [7:0]  ram_q = '0;
  logic        ram_drv = 1'b0;
  logic        pre_en = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_cs && ram_we) we_cnt <= we_cnt + 1;
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    if (ram_cs && ram_oe && !ram_we) begin
      ram_q   <= mem[ram_addr];
      ram_drv <= 1'b1;
    end else begin
      ram_drv <= 1'b0;
    end
  end
  assign ram_data = (ram_drv && ram_cs && ram_oe) ? ram_q : 'z;

  ram_bus_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_indirect(req_indirect), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_addr(rsp_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_indirect_addr(ram_indirect_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [12:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Present a request, wait (bounded) for acceptance; returns 1 ns after the accept edge E0.
  task automatic accept_req(input bit wr, input bit ind, input logic [12:0] a,
                            input logic [7:0] d, input bit hold, output bit ok);
    int n = 0;
    req_write = wr; req_indirect = ind; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = req_ready;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 30);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl: got %b want 000", {ram_cs, ram_we, ram_oe});
    end
    checks++;
    if (ram_addr !== 13'h0) begin failures++; $display("FAIL reset_addr: got %h want 0000", ram_addr); end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_addr !== 13'h0) begin
      failures++; $display("FAIL reset_rsp: got v=%b d=%h a=%h want 0/00/0000", rsp_valid, rsp_rdata, rsp_addr);
    end
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst: got %b want 0", req_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_direct_write();
    bit ok; int lat; int we0; exp_t e;
    we0 = we_cnt;
    accept_req(1'b1, 1'b0, 13'h0A5, 8'h3C, 1'b0, ok);
    exp_q.push_back('{addr: 13'h0A5, data: model_rdata});
    checks++;
    if (!ok) begin failures++; $display("FAIL dw_accept: got %b want 1", ok); end
    checks++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b110 || ram_addr !== 13'h0A5 || ram_data !== 8'h3C) begin
      failures++;
      $display("FAIL dw_bus: got ctl=%b a=%h d=%h want 110/0a5/3c", {ram_cs, ram_we, ram_oe}, ram_addr, ram_data);
    end
    wait_rsp(lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL dw_latency: got %0d want 1", lat); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rsp_addr !== e.addr || rsp_rdata !== e.data) begin
        failures++; $display("FAIL dw_rsp: got a=%h d=%h want a=%h d=%h", rsp_addr, rsp_rdata, e.addr, e.data);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || ram_cs !== 1'b0) begin
      failures++; $display("FAIL dw_pulse: got rsp_valid=%b cs=%b want 0/0", rsp_valid, ram_cs);
    end
    checks++;
    if (we_cnt - we0 !== 1) begin failures++; $display("FAIL dw_we_cycles: got %0d want 1", we_cnt - we0); end
    $display("test_direct_write a=0a5 d=3c lat=%0d", lat);
  endtask

  task automatic test_direct_read();
    bit ok; int lat; exp_t e;
    accept_req(1'b0, 1'b0, 13'h0A5, 8'h00, 1'b0, ok);
    exp_q.push_back('{addr: 13'h0A5, data: 8'h3C});
    checks++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b101 || ram_addr !== 13'h0A5) begin
      failures++; $display("FAIL dr_iss: got ctl=%b a=%h want 101/0a5", {ram_cs, ram_we, ram_oe}, ram_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b101 || ram_data !== 8'h3C) begin
      failures++; $display("FAIL dr_wt: got ctl=%b d=%h want 101/3c", {ram_cs, ram_we, ram_oe}, ram_data);
    end
    wait_rsp(lat);
    checks++;
    if (lat + 1 !== 2) begin failures++; $display("FAIL dr_latency: got %0d want 2", lat + 1); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rsp_addr !== e.addr || rsp_rdata !== e.data) begin
        failures++; $display("FAIL dr_rsp: got a=%h d=%h want a=%h d=%h", rsp_addr, rsp_rdata, e.addr, e.data);
      end
    end
    model_rdata = 8'h3C;
    $display("test_direct_read a=0a5 d=%h lat=%0d", rsp_rdata, lat + 1);
  endtask

  task automatic test_indirect_read();
    bit ok; int rsp_edge; exp_t e;
    poke(13'h010, 8'h34); poke(13'h011, 8'hE2); poke(13'h0234, 8'h5A);
    accept_req(1'b0, 1'b1, 13'h010, 8'h00, 1'b0, ok);
    exp_q.push_back('{addr: 13'h0234, data: 8'h5A});
    checks++;
    if (ram_addr !== 13'h010) begin failures++; $display("FAIL ir_addr_lo: got %h want 0010", ram_addr); end
    rsp_edge = -1;
    for (int k = 1; k <= 10 && rsp_edge < 0; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        checks++;
        if (ram_addr !== 13'h011) begin failures++; $display("FAIL ir_addr_hi: got %h want 0011", ram_addr); end
      end
      if (k == 4) begin
        checks++;
        if (ram_addr !== 13'h0234 || ram_oe !== 1'b1) begin
          failures++; $display("FAIL ir_addr_ea: got a=%h oe=%b want 0234/1", ram_addr, ram_oe);
        end
      end
      if (rsp_valid) rsp_edge = k;
    end
    checks++;
    if (rsp_edge !== 6) begin failures++; $display("FAIL ir_latency: got %0d want 6", rsp_edge); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rsp_addr !== e.addr || rsp_rdata !== e.data) begin
        failures++; $display("FAIL ir_rsp: got a=%h d=%h want a=%h d=%h", rsp_addr, rsp_rdata, e.addr, e.data);
      end
    end
    model_rdata = 8'h5A;
    $display("test_indirect_read p=010 ea=%h d=%h lat=%0d", rsp_addr, rsp_rdata, rsp_edge);
  endtask

  task automatic test_pointer_wrap();
    bit ok; int rsp_edge; int lat; exp_t e;
    poke(13'h1FFF, 8'h00); poke(13'h0000, 8'h01);
    accept_req(1'b1, 1'b1, 13'h1FFF, 8'h77, 1'b0, ok);
    exp_q.push_back('{addr: 13'h0100, data: model_rdata});
    rsp_edge = -1;
    for (int k = 1; k <= 10 && rsp_edge < 0; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        checks++;
        if (ram_addr !== 13'h0000) begin failures++; $display("FAIL wrap_hi_addr: got %h want 0000", ram_addr); end
      end
      if (k == 4) begin
        checks++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b110 || ram_addr !== 13'h0100 || ram_data !== 8'h77) begin
          failures++;
          $display("FAIL wrap_wr_bus: got ctl=%b a=%h d=%h want 110/0100/77", {ram_cs, ram_we, ram_oe}, ram_addr, ram_data);
        end
      end
      if (rsp_valid) rsp_edge = k;
    end
    checks++;
    if (rsp_edge !== 5) begin failures++; $display("FAIL wrap_latency: got %0d want 5", rsp_edge); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rsp_addr !== e.addr || rsp_rdata !== e.data) begin
        failures++; $display("FAIL wrap_rsp: got a=%h d=%h want a=%h d=%h", rsp_addr, rsp_rdata, e.addr, e.data);
      end
    end
    accept_req(1'b0, 1'b0, 13'h0100, 8'h00, 1'b0, ok);
    exp_q.push_back('{addr: 13'h0100, data: 8'h77});
    wait_rsp(lat);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.data || rsp_addr !== e.addr) begin
        failures++;
        $display("FAIL wrap_readback: got v=%b a=%h d=%h want 1/%h/%h", rsp_valid, rsp_addr, rsp_rdata, e.addr, e.data);
      end
    end
    model_rdata = 8'h77;
    $display("test_pointer_wrap p=1fff ea=0100 readback=%h lat=%0d", rsp_rdata, rsp_edge);
  endtask

  int got;
  task automatic test_back_to_back();
    logic [7:0] wd [0:15];
    int we0;
    logic [7:0] held;
    we0 = we_cnt;
    held = model_rdata;
    got = 0;
    for (int i = 0; i < 16; i++) wd[i] = 8'($urandom_range(0, 255));
    fork
      begin
        bit ok; int prev; bit wr; logic [12:0] a;
        prev = 0;
        for (int i = 0; i < 32; i++) begin
          wr = (i < 16);
          a = 13'(i % 16);
          accept_req(wr, 1'b0, a, wr ? wd[i % 16] : 8'h00, 1'b1, ok);
          exp_q.push_back('{addr: a, data: wr ? held : wd[i % 16]});
          checks++;
          if (!ok) begin failures++; $display("FAIL b2b_accept: req %0d got %b want 1", i, ok); end
          if (i > 0 && i != 16) begin
            checks++;
            if (cyc - prev !== (wr ? 2 : 3)) begin
              failures++; $display("FAIL b2b_interval: req %0d got %0d want %0d", i, cyc - prev, wr ? 2 : 3);
            end
          end
          prev = cyc;
        end
        req_valid = 1'b0;
      end
      begin
        int guard = 0;
        exp_t e;
        while (got < 32 && guard < 300) begin
          @(posedge clk); #1;
          guard++;
          if (rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL b2b_extra_rsp: got rsp a=%h want none", rsp_addr);
            end else begin
              e = exp_q.pop_front();
              if (rsp_addr !== e.addr || rsp_rdata !== e.data) begin
                failures++;
                $display("FAIL b2b_rsp: #%0d got a=%h d=%h want a=%h d=%h", got, rsp_addr, rsp_rdata, e.addr, e.data);
              end
            end
            got++;
          end
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got !== 32 || exp_q.size() !== 0) begin
      failures++; $display("FAIL b2b_count: got %0d rsp, %0d pending want 32/0", got, exp_q.size());
    end
    checks++;
    if (we_cnt - we0 !== 16) begin failures++; $display("FAIL b2b_we_cycles: got %0d want 16", we_cnt - we0); end
    model_rdata = wd[15];
    $display("test_back_to_back responses=%0d writes=%0d", got, we_cnt - we0);
  endtask

  task automatic test_reset_abort();
    bit ok; int bad_rsp; int we0;
    poke(13'h020, 8'h40); poke(13'h021, 8'h03); poke(13'h0340, 8'hAA);
    accept_req(1'b1, 1'b1, 13'h020, 8'h55, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1;
    we0 = we_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ram_cs !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL abort_bus: got cs=%b rsp_valid=%b want 0/0", ram_cs, rsp_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    bad_rsp = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) bad_rsp++;
    end
    checks++;
    if (bad_rsp !== 0 || we_cnt !== we0) begin
      failures++; $display("FAIL abort_no_rsp: got rsp=%0d we=%0d want 0/0", bad_rsp, we_cnt - we0);
    end
    checks++;
    if (mem[13'h0340] !== 8'hAA) begin failures++; $display("FAIL abort_target: got %h want aa", mem[13'h0340]); end
    $display("test_reset_abort target=%h", mem[13'h0340]);
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_direct_read();
    test_indirect_read();
    test_pointer_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Synchronous initiator for the single-port sync RAM bus (`cs`/`we`/`oe`/`addr`/`data`, with tri-state `data`). It accepts byte read and write requests on a valid/ready port and sequences the RAM pins. It also resolves indirect requests: a 13-bit pointer is fetched from RAM, then the target location is accessed. It sits between CPU-side logic and the RAM and replaces hand-driven bus stimulus.

## Interface
- `ADDR_WIDTH`, 13, RAM address width.
- `DATA_WIDTH`, 8, RAM data width; pointer format below requires 8.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  equals (state==IDLE && !rst); a transfer occurs when both `req_valid` and `req_ready` are 1 at a rising edge.
- `req_write`  in  1  1 = write, 0 = read.
- `req_indirect`  in  1  1 = `req_addr` is a pointer location.
- `req_addr`  in  ADDR_WIDTH  direct address or pointer location P.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_WIDTH  read data; updated only on reads, otherwise held.
- `rsp_addr`  out  ADDR_WIDTH  effective address of the completed access.
- `ram_cs`, `ram_we`, `ram_oe`  out  1  RAM controls, registered.
- `ram_addr`  out  ADDR_WIDTH  RAM address, registered.
- `ram_indirect_addr`  out  ADDR_WIDTH  reserved; tied to 0.
- `ram_data`  inout  DATA_WIDTH  driven with the write byte only when `ram_cs & ram_we & !ram_oe`; otherwise `'z`.

## Operation
- States: IDLE, PLO_ISS, PLO_WT, PHI_ISS, PHI_WT, RD_ISS, RD_WT, WR.
- Request capture: `req_*` fields are registered at the accept edge.
- IDLE transitions on accept:
  - indirect request → PLO_ISS
  - direct read → RD_ISS
  - direct write → WR
- Bus encoding per state (registered, valid for the whole state):
  - PLO_ISS/PLO_WT/PHI_ISS/PHI_WT/RD_ISS/RD_WT: `cs=1, we=0, oe=1`.
  - WR: `cs=1, we=1, oe=0`, `ram_data=wdata`.
  - IDLE: `cs=0, we=0, oe=0`, `ram_data` released.
- Read protocol:
  - The RAM samples `addr` at the end of an ISS state.
  - Data is valid during the following WT state.
  - The master captures `ram_data` at the end of WT.
- Indirect pointer fetch:
  - PLO reads address P → `ptr_lo`.
  - PHI reads address (P+1) mod 2^13; 0x1FFF wraps to 0x0000. This byte → `ptr_hi`.
  - EA = {`ptr_hi[4:0]`, `ptr_lo`}. `ptr_hi[7:5]` is ignored.
  - PHI_WT → RD_ISS or WR, with `ram_addr`=EA.
  - PLO_WT → PHI_ISS directly; there is no idle gap.
- Completion:
  - At the edge leaving RD_WT or WR, the state returns to IDLE.
  - `rsp_valid`=1 for the next cycle only.
  - `rsp_addr`=EA, or `req_addr` when direct.
  - `rsp_rdata` is loaded on reads.
- `req_valid` seen outside IDLE is ignored and not queued. The requester holds it until `req_ready`.
- No request is accepted in the cycle `rst` is high.

## Timing
- Accept edge = E0.
- Completion latency (edge at which `rsp_valid` rises):
  - direct write: E1
  - direct read: E2
  - indirect write: E5
  - indirect read: E6
- Throughput with `req_valid` held high:
  - direct write: one per 2 cycles
  - direct read: one per 3 cycles
  - indirect write: one per 6 cycles
  - indirect read: one per 7 cycles
- A write's `ram_we` is high for exactly one cycle per request.
- Reset values (at the first edge with `rst`=1):
  - state IDLE
  - `ram_cs`, `ram_we`, `ram_oe`=0
  - `ram_addr`=0, `ram_data` released
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_addr`=0
  - internal pointer registers 0
- Reset mid-operation:
  - The in-flight request is aborted; no `rsp_valid` is produced for it.
  - A partial write never occurs after the reset edge.
  - `req_ready`=1 in the first cycle after `rst` deasserts.

## Test plan
- Direct write A=0x0A5, D=0x3C, starting from idle:
  - Exactly one cycle with `ram_cs=1, we=1, oe=0, ram_addr=0x0A5, ram_data=0x3C`.
  - `rsp_valid` at E1 with `rsp_addr=0x0A5`.
  - `rsp_rdata` unchanged.
- Direct read of 0x0A5 after that write:
  - `ram_we=0, ram_oe=1` for 2 cycles.
  - `rsp_valid` at E2, `rsp_rdata=0x3C`.
  - `ram_data` never driven by the master.
- Indirect read. Preload mem[0x010]=0x34, mem[0x011]=0xE2, mem[0x0234]=0x5A; request read at P=0x010:
  - bus addresses 0x010, 0x011, 0x0234 in order
  - `rsp_addr=0x0234`, `rsp_rdata=0x5A`
  - `rsp_valid` at E6
- Pointer wrap. mem[0x1FFF]=0x00, mem[0x0000]=0x01; indirect write P=0x1FFF, D=0x77:
  - hi byte fetched from 0x0000
  - write lands at 0x0100; readback gives 0x77
  - `rsp_valid` at E5
- Back-to-back. `req_valid` held high; 16 writes of random data to addresses 0..15, then 16 reads:
  - writes accepted every 2 cycles, reads every 3
  - every read matches its write
  - no request lost or duplicated
- Reset abort:
  - Assert `rst` for one cycle while in PHI_WT of an indirect write.
  - Next edge: `ram_cs=0`, no `rsp_valid`, target byte unchanged.
  - `req_ready`=1 the cycle after release.
